// File: rtl/mips_mc_ctrl.sv
// Multi-cycle main control FSM for MIPS-Lite3: sequences IF/ID/EXE/MEM/WB and stalls on mem_ready.
// Optional macro CTRL_ILLEGAL_TRAP_EN: undecoded instructions enter a sticky TRAP state with illegal=1.
module mips_mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_b,
    output logic       ext_op,
    output logic [2:0] alu_ctrl,
    output logic       illegal
);
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_LUI = 3'b100;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MA   = 4'd2,
        S_MR   = 4'd3,
        S_MW   = 4'd4,
        S_WBM  = 4'd5,
        S_EXR  = 4'd6,
        S_EXI  = 4'd7,
        S_WBA  = 4'd8,
        S_BR   = 4'd9,
        S_JMP  = 4'd10,
        S_TRAP = 4'd11
    } state_t;

    state_t state_q, state_d;

    logic is_rtype, is_addu, is_subu, is_slt, is_jr;
    logic is_lw, is_sw, is_ori, is_lui, is_addi, is_addiu, is_beq, is_j, is_jal;
    logic is_ralu, is_ialu;
    logic [2:0] exe_alu;

    assign is_rtype = (opcode == 6'b000000);
    assign is_addu  = is_rtype && (funct == 6'b100001);
    assign is_subu  = is_rtype && (funct == 6'b100011);
    assign is_slt   = is_rtype && (funct == 6'b101010);
    assign is_jr    = is_rtype && (funct == 6'b001000);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);
    assign is_ori   = (opcode == 6'b001101);
    assign is_lui   = (opcode == 6'b001111);
    assign is_addi  = (opcode == 6'b001000);
    assign is_addiu = (opcode == 6'b001001);
    assign is_beq   = (opcode == 6'b000100);
    assign is_j     = (opcode == 6'b000010);
    assign is_jal   = (opcode == 6'b000011);
    assign is_ralu  = is_addu || is_subu || is_slt;
    assign is_ialu  = is_ori || is_lui || is_addi || is_addiu;

    // Shared by EXR/EXI and WBA so alu_ctrl stays stable across the ALUOut write-back.
    always_comb begin
        exe_alu = ALU_ADD;
        if (is_subu)     exe_alu = ALU_SUB;
        else if (is_slt) exe_alu = ALU_SLT;
        else if (is_ori) exe_alu = ALU_OR;
        else if (is_lui) exe_alu = ALU_LUI;
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    always_comb begin
        state_d    = reset ? S_IF : state_q;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_b  = 1'b0;
        ext_op     = 1'b0;
        alu_ctrl   = ALU_ADD;
        illegal    = 1'b0;
        // Reset masks every output so an aborted instruction cannot write anything.
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_ID;
                    end
                end
                S_ID: begin
                    if (is_lw || is_sw)       state_d = S_MA;
                    else if (is_ralu)         state_d = S_EXR;
                    else if (is_jr)           state_d = S_JMP;
                    else if (is_ialu)         state_d = S_EXI;
                    else if (is_beq)          state_d = S_BR;
                    else if (is_j || is_jal)  state_d = S_JMP;
                    else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_IF;
`endif
                    end
                end
                S_MA: begin
                    alu_ctrl  = ALU_ADD;
                    alu_src_b = 1'b1;
                    ext_op    = 1'b1;
                    if (is_lw)      state_d = S_MR;
                    else if (is_sw) state_d = S_MW;
                    else            state_d = S_IF;
                end
                S_MR: begin
                    mem_read = 1'b1;
                    if (mem_ready) state_d = S_WBM;
                end
                S_MW: begin
                    mem_write = 1'b1;
                    if (mem_ready) state_d = S_IF;
                end
                S_WBM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                    state_d    = S_IF;
                end
                S_EXR: begin
                    alu_ctrl = exe_alu;
                    state_d  = S_WBA;
                end
                S_EXI: begin
                    alu_src_b = 1'b1;
                    alu_ctrl  = exe_alu;
                    ext_op    = is_addi || is_addiu;
                    state_d   = S_WBA;
                end
                S_WBA: begin
                    reg_write = 1'b1;
                    reg_dst   = is_rtype ? 2'b01 : 2'b00;
                    alu_ctrl  = exe_alu;
                    state_d   = S_IF;
                end
                S_BR: begin
                    alu_ctrl = ALU_SUB;
                    pc_write = zero;
                    pc_src   = 2'b01;
                    state_d  = S_IF;
                end
                S_JMP: begin
                    pc_write = 1'b1;
                    pc_src   = is_jr ? 2'b11 : 2'b10;
                    if (is_jal) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                    state_d = S_IF;
                end
                S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    illegal = 1'b1;
                    state_d = S_TRAP;
`else
                    state_d = S_IF;
`endif
                end
                default: state_d = S_IF;
            endcase
        end
    end

    assign state = state_q;
endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multi-cycle main control FSM for the MIPS-Lite3 processor. It sequences the shared ALU, register file, instruction register, PC and unified memory across IF/ID/EXE/MEM/WB states. It decodes opcode/funct from the IR, drives alu_ctrl using the ALU_* codes in definitions.vh, and resolves beq using the ALU zero flag. It stalls on a memory-ready handshake.

Parameters:
none; encodings come from definitions.vh. ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_OR=3'b010, ALU_SLT=3'b011, ALU_LUI=3'b100.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
state  out  4  current state, for debug
pc_write  out  1  PC load enable
pc_src  out  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target, 11 rs
ir_write  out  1  IR load enable
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write enable
reg_dst  out  2  destination select: 00 rt, 01 rd, 10 $31
mem_to_reg  out  2  write-back data select: 00 ALUOut, 01 MDR, 10 PC+4
alu_src_b  out  1  ALU b input select: 0 rt data, 1 extended immediate
ext_op  out  1  immediate extension: 0 zero-extend, 1 sign-extend
alu_ctrl  out  3  ALU operation
illegal  out  1  see Optional Feature

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- State register (4-bit) updates on the posedge of clk. While reset=1, the next state is IF.
- Outputs are decoded combinationally from state, opcode and funct (Moore, plus zero for beq). Every enable and mux output not named for a state is 0.
- Reset values: state=IF(0). All write enables are 0 during the reset cycle; the IF decode is gated by reset.
- State encodings: IF=0, ID=1, MA=2, MR=3, MW=4, WBM=5, EXR=6, EXI=7, WBA=8, BR=9, JMP=10, TRAP=11.
- IF:
  - mem_read=1.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=00, next state ID.
  - Otherwise stay in IF with ir_write=0 and pc_write=0.
- ID: no enables. Next state by opcode:
  - lw, sw → MA
  - R-type (000000) with funct addu(100001), subu(100011) or slt(101010) → EXR
  - R-type with funct jr(001000) → JMP
  - ori(001101), lui(001111), addi(001000), addiu(001001) → EXI
  - beq(000100) → BR
  - j(000010), jal(000011) → JMP
  - anything else → IF (or TRAP with the feature enabled).
- MA: alu_ctrl=ADD, alu_src_b=1, ext_op=1. lw → MR; sw → MW.
- MR: mem_read=1. If mem_ready=1 → WBM, else hold.
- MW: mem_write=1, held while mem_ready=0. If mem_ready=1 → IF.
- WBM: reg_write=1, reg_dst=00, mem_to_reg=01. Next state IF.
- EXR: alu_src_b=0; alu_ctrl = ADD for addu, SUB for subu, SLT for slt. Next state WBA.
- EXI: alu_src_b=1. Next state WBA.
  - ori: alu_ctrl=OR, ext_op=0.
  - lui: alu_ctrl=LUI.
  - addi, addiu: alu_ctrl=ADD, ext_op=1.
- WBA: reg_write=1, mem_to_reg=00; reg_dst=01 for R-type, 00 otherwise. alu_ctrl keeps the EXE value (ALUOut is registered in the datapath). Next state IF.
- BR: alu_ctrl=SUB, alu_src_b=0; pc_write=zero, pc_src=01. Next state IF.
- JMP: pc_write=1. Next state IF.
  - j: pc_src=10.
  - jal: pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
  - jr: pc_src=11.
- Latency in cycles with no stalls: lw 5; sw, R-type and I-type ALU 4; beq, j, jal and jr 3. Each mem_ready=0 cycle adds one.
- A reset asserted mid-instruction aborts it: no write enable is asserted in the reset cycle, and the FSM restarts at IF.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Undecoded opcode/funct in ID goes to TRAP.
  - TRAP asserts illegal=1, holds all write enables at 0, and stays in TRAP until reset.
- Undefined:
  - illegal is tied to 0.
  - Undecoded instructions return to IF as a NOP, with no writes; PC has already advanced.

Test Plan:
- Reset: hold reset for 2 cycles, then release with mem_ready=1 → state=0, all enables 0 during reset; in the first IF cycle ir_write=1, pc_write=1.
- addu: opcode=000000, funct=100001, mem_ready=1 → states 0,1,6,8; EXR alu_ctrl=000; WBA reg_write=1, reg_dst=01; 4 cycles total.
- lw with memory stalls: opcode=100011, mem_ready low for 2 cycles in both IF and MR → states 0,0,0,1,2,3,3,3,5; MA alu_ctrl=000, ext_op=1; WBM mem_to_reg=01; 9 cycles total.
- beq:
  - opcode=000100, zero=1 → BR with alu_ctrl=001, pc_write=1, pc_src=01.
  - Repeat with zero=0 → pc_write=0 in BR.
- lui, ori, jal:
  - lui → EXI alu_ctrl=100.
  - ori → EXI alu_ctrl=010, ext_op=0.
  - jal → JMP reg_dst=10, mem_to_reg=10, pc_src=10, reg_write=1.
- Illegal instruction: opcode=111111 → without macro, next state after ID is 0 with no writes; with CTRL_ILLEGAL_TRAP_EN, state=11, illegal=1, held until reset.
